// File: rtl/ultrasonido_pkg.sv
// Shared types and default timing constants for the ultrasonic ranger.
package ultrasonido_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned TRIG_CYCLES     = 500;        // 10 us trigger pulse
  localparam int unsigned TIMEOUT_CYCLES  = 1_500_000;  // 30 ms wait for echo rise
  localparam int unsigned MAX_ECHO_CYCLES = 1_000_000;  // over-range echo width
  localparam int unsigned HOLDOFF_CYCLES  = 3_000_000;  // 60 ms dead time
  localparam int unsigned NEAR_CYCLES     = 58_000;     // ~20 cm
  localparam int unsigned CNT_W           = 20;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_ECHO = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw echo pin plus a one-flop edge detector.
// Rise/fall pulses are one cycle wide and derived from registered values.
module echo_sync
  import ultrasonido_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_echo,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Metastability chain followed by the previous-level flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_echo};
      r_prev <= r_sync[1];
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_prev;
  assign o_fall  = ~r_sync[1] & r_prev;

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// Measurement sequencer: trigger pulse, echo timing with timeout and
// saturation, and inter-measurement hold-off, single-shot or auto-repeat.
//
// Result strobe: `valid` is high for exactly one cycle; `width`, `timeout`
// and `near` change only on that same edge and hold until the next strobe.
// There is no back-pressure; a consumer must capture on `valid`.
module ultrasonic_ranger_ctrl
  import ultrasonido_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES     = ultrasonido_pkg::TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = ultrasonido_pkg::TIMEOUT_CYCLES,
  parameter int unsigned MAX_ECHO_CYCLES = ultrasonido_pkg::MAX_ECHO_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = ultrasonido_pkg::HOLDOFF_CYCLES,
  parameter int unsigned NEAR_CYCLES     = ultrasonido_pkg::NEAR_CYCLES,
  parameter int unsigned CNT_W           = ultrasonido_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic [CNT_W-1:0] width,
  output logic             valid,
  output logic             timeout,
  output logic             near,
  output state_t           dbg_state
);

  // The shared counter also times the trigger, the echo wait and the
  // hold-off, which can exceed the measurement width, so it is widened to
  // whichever is larger.
  localparam int unsigned SPAN = umax(umax(TRIG_CYCLES, TIMEOUT_CYCLES),
                                      umax(MAX_ECHO_CYCLES, HOLDOFF_CYCLES));
  localparam int unsigned CW   = umax(CNT_W, $clog2(SPAN + 1));

  localparam logic [CW-1:0]    TRIG_LAST    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    MAX_LAST     = CW'(MAX_ECHO_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST    = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0]    NEAR_LIM     = CW'(NEAR_CYCLES);
  localparam logic [CNT_W-1:0] MAX_WIDTH    = CNT_W'(MAX_ECHO_CYCLES);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_next;
  logic          w_echo_level;
  logic          w_echo_rise;
  logic          w_echo_fall;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst     (rst),
    .i_echo  (echo),
    .o_level (w_echo_level),
    .o_rise  (w_echo_rise),
    .o_fall  (w_echo_fall)
  );

  // In MEASURE the cycle being counted is included, so the width reported
  // on a fall is the counter plus one; this also equals the raw pulse width.
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_cnt_next = (&r_cnt) ? r_cnt : w_cnt_inc;
  assign dbg_state  = r_state;

  // Sequencer FSM with the shared saturating counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      trig    <= 1'b0;
      busy    <= 1'b0;
      width   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      near    <= 1'b0;
    end else begin
      valid <= 1'b0;
      r_cnt <= w_cnt_next;
      case (r_state)
        S_IDLE: begin
          if (start || enable) begin
            r_state <= S_TRIG;
            r_cnt   <= '0;
            trig    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_TRIG: begin
          if (r_cnt >= TRIG_LAST) begin
            r_state <= S_WAIT_ECHO;
            r_cnt   <= '0;
            trig    <= 1'b0;
          end
        end
        S_WAIT_ECHO: begin
          // An edge in the final wait cycle still starts a measurement.
          if (w_echo_rise) begin
            r_state <= S_MEASURE;
            r_cnt   <= '0;
          end else if (r_cnt >= TIMEOUT_LAST) begin
            r_state <= S_HOLDOFF;
            r_cnt   <= '0;
            width   <= '0;
            timeout <= 1'b1;
            near    <= 1'b0;
            valid   <= 1'b1;
          end
        end
        S_MEASURE: begin
          // Over-range takes priority over a coincident falling edge.
          if (r_cnt >= MAX_LAST) begin
            r_state <= S_HOLDOFF;
            r_cnt   <= '0;
            width   <= MAX_WIDTH;
            timeout <= 1'b1;
            near    <= 1'b0;
            valid   <= 1'b1;
          end else if (w_echo_fall || !w_echo_level) begin
            r_state <= S_HOLDOFF;
            r_cnt   <= '0;
            width   <= w_cnt_inc[CNT_W-1:0];
            timeout <= 1'b0;
            near    <= (w_cnt_inc < NEAR_LIM);
            valid   <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt >= HOLD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          trig    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl with a result scoreboard.
module tb_ultrasonic_ranger_ctrl;
  import ultrasonido_pkg::*;

  localparam int W        = 20;
  localparam int TRIG_LEN = 10;
  localparam int HOLD     = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         enable = 1'b0;
  logic         echo = 1'b0;
  logic         trig, busy, valid, timeout, near;
  logic [W-1:0] width;
  state_t       dbg_state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int trig_rises = 0;
  int launches = 0;
  int f;

  logic [W+1:0] exp_q[$];
  int           exp_t_q[$];
  int           rise_q[$];

  ultrasonic_ranger_ctrl #(
    .TRIG_CYCLES     (10),
    .TIMEOUT_CYCLES  (1000),
    .MAX_ECHO_CYCLES (800),
    .HOLDOFF_CYCLES  (50),
    .NEAR_CYCLES     (200),
    .CNT_W           (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .busy      (busy),
    .width     (width),
    .valid     (valid),
    .timeout   (timeout),
    .near      (near),
    .dbg_state (dbg_state)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+1:0] res(input logic t, input logic n, input int w);
    return {t, n, W'(w)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic bail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event required=event", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: pops the scoreboard on every valid, checks trig length and
  // the busy release 50 cycles after each result.
  task automatic monitor();
    logic         trig_q = 1'b0;
    logic         busy_q = 1'b0;
    logic         armed = 1'b0;
    int           run = 0;
    int           last_v = 0;
    logic [W+1:0] e;
    int           et;
    forever begin
      @(negedge clk);
      if (rst) begin
        trig_q = 1'b0;
        busy_q = 1'b0;
        armed  = 1'b0;
        run    = 0;
      end else begin
        if (trig && !trig_q) begin
          trig_rises++;
          rise_q.push_back(cyc);
        end
        if (trig) run++;
        else if (trig_q) begin
          chk("trig_len", run, TRIG_LEN);
          run = 0;
        end
        if (valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=0x%0h required=none", {timeout, near, width});
          end else begin
            e  = exp_q.pop_front();
            et = exp_t_q.pop_front();
            chk("result", {timeout, near, width}, e);
            chk("valid_cycle", cyc, et);
          end
          armed  = 1'b1;
          last_v = cyc;
        end
        if (!busy && busy_q && armed) begin
          chk("busy_release", cyc, last_v + HOLD);
          armed = 1'b0;
        end
        trig_q = trig;
        busy_q = busy;
      end
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_trig_fall(output int fe);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 3000) bail("trig_rise_wait");
    end while (!trig);
    do begin
      @(negedge clk);
      n++;
      if (n > 3000) bail("trig_fall_wait");
    end while (trig);
    fe = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 5000) bail("busy_low_wait");
    end while (busy);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Called at the negedge after trig fell (edge fe). Pulses start while
  // busy, raises echo after edge fe+d and drops it after edge fe+d+w.
  task automatic echo_pulse(input int d, input int w);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (d - 2) begin @(posedge clk); #1; end
    if (w > 0) begin
      echo = 1'b1;
      repeat (w) begin @(posedge clk); #1; end
      echo = 1'b0;
    end
  endtask

  // One single-shot measurement; lat is the valid edge relative to trig fall.
  task automatic run_shot(input int d, input int w, input logic [W+1:0] e, input int lat);
    int fe;
    pulse_start();
    wait_trig_fall(fe);
    launches++;
    exp_q.push_back(e);
    exp_t_q.push_back(fe + lat);
    echo_pulse(d, w);
    wait_idle();
  endtask

  initial begin
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_width", width, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_near", near, 0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_trig", trig, 0);

    // width = w, valid at trig fall + d + w + 3
    run_shot(5, 150, res(1'b0, 1'b1, 150), 158);
    run_shot(5, 300, res(1'b0, 1'b0, 300), 308);
    // no echo: timeout 1000 cycles after trig end
    run_shot(2, 0, res(1'b1, 1'b0, 0), 1000);
    // over-range at 800, echo falls during hold-off
    run_shot(5, 820, res(1'b1, 1'b0, 800), 808);
    run_shot(2, 2, res(1'b0, 1'b1, 2), 7);
    run_shot(5, 199, res(1'b0, 1'b1, 199), 207);
    run_shot(5, 200, res(1'b0, 1'b0, 200), 208);
    run_shot(5, 799, res(1'b0, 1'b0, 799), 807);
    // fall coincident with reaching 800: over-range wins
    run_shot(5, 800, res(1'b1, 1'b0, 800), 808);
    // rise pulse lands in the last wait cycle: edge wins
    run_shot(997, 100, res(1'b0, 1'b1, 100), 1100);
    // rise one cycle too late: timeout
    run_shot(998, 100, res(1'b1, 1'b0, 0), 1000);

    // echo stuck high across the trigger: no edge, timeout
    echo = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    wait_trig_fall(f);
    launches++;
    exp_q.push_back(res(1'b1, 1'b0, 0));
    exp_t_q.push_back(f + 1000);
    repeat (1020) begin @(posedge clk); #1; end
    echo = 1'b0;
    wait_idle();

    // continuous mode: period = trig 10 + echo start 5 + width 100
    // + fall-to-valid 3 + hold-off 50 + one IDLE cycle = 169
    rise_q.delete();
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_trig_fall(f);
      launches++;
      exp_q.push_back(res(1'b0, 1'b1, 100));
      exp_t_q.push_back(f + 108);
      if (k == 2) enable = 1'b0;
      echo_pulse(5, 100);
    end
    wait_idle();
    repeat (300) @(posedge clk);
    #1;
    chk("enable_trig_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("enable_period_1", rise_q[1] - rise_q[0], 169);
      chk("enable_period_2", rise_q[2] - rise_q[1], 169);
    end

    // reset mid-MEASURE
    pulse_start();
    wait_trig_fall(f);
    launches++;
    repeat (5) begin @(posedge clk); #1; end
    echo = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("pre_rst_state", 32'(dbg_state), 32'(S_MEASURE));
    chk("pre_rst_width", width, 100);
    #2 rst = 1'b1;
    #1;
    chk("rst_meas_trig", trig, 0);
    chk("rst_meas_busy", busy, 0);
    chk("rst_meas_width", width, 0);
    chk("rst_meas_timeout", timeout, 0);
    chk("rst_meas_state", 32'(dbg_state), 32'(S_IDLE));
    echo = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_shot(5, 60, res(1'b0, 1'b1, 60), 68);

    // reset mid-TRIG
    pulse_start();
    launches++;
    chk("pre_rst2_state", 32'(dbg_state), 32'(S_TRIG));
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst2_trig", trig, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_trig_trig", trig, 0);
    chk("rst_trig_busy", busy, 0);
    chk("rst_trig_width", width, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_shot(5, 250, res(1'b0, 1'b0, 250), 258);

    repeat (20) @(posedge clk);
    #1;
    chk("pending_results", exp_q.size(), 0);
    chk("total_triggers", trig_rises, launches);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
